mic1_regfile: RTL

- MIC-1 datapath register file that sits directly upstream of the ALU.
- Holds H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR and MBR.
- Drives the ALU A input from H and the ALU B input from a selected B-bus source.
- Latches the shifter C-bus result into any subset of registers, accepts memory read data into MDR/MBR, and registers the ALU N/Z flags for microsequencer branching.

---
 rtl/mic1_pkg.sv | 29 ++
 rtl/mic1_reg.sv | 17 +
 rtl/mic1_regfile.sv | 98 +++++++++
 3 files changed

// File: rtl/mic1_pkg.sv
// mic1_pkg: shared constants, B-bus select encoding and C-bus write-enable bit positions.
package mic1_pkg;
  localparam int WORD_W_DEF = 32;
  typedef enum logic [3:0] {
    BSEL_MDR  = 4'd0,
    BSEL_PC   = 4'd1,
    BSEL_MBR  = 4'd2,
    BSEL_MBRU = 4'd3,
    BSEL_SP   = 4'd4,
    BSEL_LV   = 4'd5,
    BSEL_CPP  = 4'd6,
    BSEL_TOS  = 4'd7,
    BSEL_OPC  = 4'd8
  } b_sel_e;
  localparam int CSEL_MAR = 0;
  localparam int CSEL_MDR = 1;
  localparam int CSEL_PC  = 2;
  localparam int CSEL_SP  = 3;
  localparam int CSEL_LV  = 4;
  localparam int CSEL_CPP = 5;
  localparam int CSEL_TOS = 6;
  localparam int CSEL_OPC = 7;
  localparam int CSEL_H   = 8;
  localparam int NUM_REGS = 9;
  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_0000;
  localparam logic [31:0] SP_RESET_DEF  = 32'h0000_8000;
  localparam logic [31:0] LV_RESET_DEF  = 32'h0000_8000;
  localparam logic [31:0] CPP_RESET_DEF = 32'h0000_4000;
endpackage

// File: rtl/mic1_reg.sv
// mic1_reg: enabled datapath register with parameterised reset value and async active-low reset.
module mic1_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= RESET_VAL;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/mic1_regfile.sv
// mic1_regfile: MIC-1 register file feeding the ALU A/B buses, with MDR/MBR memory loads and N/Z flags.
// Define MIC1_BBUS_CHECK_EN to flag out-of-range B-bus selects on bbus_err.
module mic1_regfile
  import mic1_pkg::*;
#(
  parameter int                WORD_W    = WORD_W_DEF,
  parameter logic [WORD_W-1:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [WORD_W-1:0] SP_RESET  = SP_RESET_DEF,
  parameter logic [WORD_W-1:0] LV_RESET  = LV_RESET_DEF,
  parameter logic [WORD_W-1:0] CPP_RESET = CPP_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] c_bus,
  input  logic [8:0]        c_sel,
  input  logic [3:0]        b_sel,
  input  logic              mdr_load,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mbr_load,
  input  logic [7:0]        mem_rbyte,
  input  logic              alu_n,
  input  logic              alu_z,
  output logic [WORD_W-1:0] a_bus,
  output logic [WORD_W-1:0] b_bus,
  output logic [WORD_W-1:0] mar,
  output logic [WORD_W-1:0] mdr,
  output logic [WORD_W-1:0] pc,
  output logic              n_flag,
  output logic              z_flag,
  output logic              wr_conflict,
  output logic              bbus_err
);
  logic [WORD_W-1:0] w_q [NUM_REGS];
  logic [7:0]        r_mbr;
  logic              r_n, r_z, r_conflict;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [WORD_W-1:0] RV = (i == CSEL_PC)  ? PC_RESET  :
                                       (i == CSEL_SP)  ? SP_RESET  :
                                       (i == CSEL_LV)  ? LV_RESET  :
                                       (i == CSEL_CPP) ? CPP_RESET : '0;
    localparam bit IS_MDR = (i == CSEL_MDR);
    logic              w_en;
    logic [WORD_W-1:0] w_d;
    // memory data only reaches MDR, and only when the C-bus is not also writing it
    assign w_en = c_sel[i] | (IS_MDR & mdr_load);
    assign w_d  = (IS_MDR && !c_sel[i]) ? mem_rdata : c_bus;
    mic1_reg #(.W(WORD_W), .RESET_VAL(RV)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_en),
      .i_d   (w_d),
      .o_q   (w_q[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mbr      <= '0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (mbr_load) r_mbr <= mem_rbyte;
      r_n        <= alu_n;
      r_z        <= alu_z;
      r_conflict <= c_sel[CSEL_MDR] & mdr_load;
    end
  always_comb begin
    b_bus = '0;
    case (b_sel_e'(b_sel))
      BSEL_MDR:  b_bus = w_q[CSEL_MDR];
      BSEL_PC:   b_bus = w_q[CSEL_PC];
      BSEL_MBR:  b_bus = {{(WORD_W-8){r_mbr[7]}}, r_mbr};
      BSEL_MBRU: b_bus = {{(WORD_W-8){1'b0}}, r_mbr};
      BSEL_SP:   b_bus = w_q[CSEL_SP];
      BSEL_LV:   b_bus = w_q[CSEL_LV];
      BSEL_CPP:  b_bus = w_q[CSEL_CPP];
      BSEL_TOS:  b_bus = w_q[CSEL_TOS];
      BSEL_OPC:  b_bus = w_q[CSEL_OPC];
      default:   b_bus = '0;
    endcase
  end
`ifdef MIC1_BBUS_CHECK_EN
  logic r_bbus_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_bbus_err <= 1'b0;
    else r_bbus_err <= (b_sel > 4'd8);
  assign bbus_err = r_bbus_err;
`else
  assign bbus_err = 1'b0;
`endif
  assign a_bus       = w_q[CSEL_H];
  assign mar         = w_q[CSEL_MAR];
  assign mdr         = w_q[CSEL_MDR];
  assign pc          = w_q[CSEL_PC];
  assign n_flag      = r_n;
  assign z_flag      = r_z;
  assign wr_conflict = r_conflict;
endmodule
